boot_rom_copy_engine: RTL and testbench
=======================================

Name: boot_rom_copy_engine

Overview:
- Boot-time initiator for the on-chip boot ROM's read interface.
- Drives the ROM's chip-select and word address, and collects read data returned one cycle later with a valid flag.
- Writes each word into main SRAM over a req/gnt write port.
- Used by the boot controller to shadow ROM contents into RAM, accumulating a running checksum, before releasing the core.

Parameters:
- Width, 32: data word width (ROM and RAM).
- RomAw, 12: ROM word-address width (4096-word ROM).
- RamAw, 14: RAM word-address width.
- FifoDepth, 4: read-data buffer entries, power of two, >= 2.

Ports:
- clk_i  input  1  clock; all logic on rising edge.
- rst_ni  input  1  reset, asynchronous, active-low.
- start_i  input  1  one-cycle pulse; begin copy with the current configuration.
- src_addr_i  input  RomAw  first ROM word address.
- dst_addr_i  input  RamAw  first RAM word address.
- len_i  input  RomAw+1  number of words to copy (0..2^RomAw).
- busy_o  output  1  copy in progress.
- done_o  output  1  sticky completion flag.
- checksum_o  output  Width  sum of all words written, mod 2^Width.
- rom_cs_o  output  1  ROM read strobe.
- rom_addr_o  output  RomAw  ROM word address.
- rom_dout_i  input  Width  ROM read data.
- rom_dvalid_i  input  1  ROM data valid; arrives exactly 1 cycle after rom_cs_o.
- ram_req_o  output  1  RAM write request.
- ram_we_o  output  1  RAM write enable; equals ram_req_o.
- ram_addr_o  output  RamAw  RAM word address.
- ram_wdata_o  output  Width  RAM write data.
- ram_gnt_i  input  1  RAM accepts the current request this cycle.

Behaviour:
- Reset (async assert, sync deassert): all outputs 0, FSM in IDLE, FIFO empty, counters 0. Reset mid-copy aborts immediately.
  - rom_cs_o and ram_req_o drop in the same cycle the reset asserts.
  - No residual write is issued after reset is released.
  - A ROM read in flight at reset is discarded.
- FSM states: IDLE, COPY, DONE.
  - IDLE/DONE, start_i=1: latch src, dst and len; clear checksum_o and done_o; go to COPY (busy_o=1 from the next cycle).
  - If the latched len is 0: COPY goes to DONE on the next cycle with no ROM or RAM traffic.
  - In COPY, start_i is ignored.
  - COPY goes to DONE on the cycle after the last RAM write is granted. done_o=1 and busy_o=0 from the first DONE cycle.
  - DONE holds until start_i or reset.
- ROM read issue rule: rom_cs_o=1 in a COPY cycle iff reads_issued < len AND (fifo_count + inflight) < FifoDepth.
  - inflight is 1 if rom_cs_o was high in the previous cycle, else 0.
  - There is no pop lookahead.
  - rom_addr_o = src + reads_issued, mod 2^RomAw (wraps from 0xFFF to 0x000).
  - rom_addr_o holds its last value when rom_cs_o=0.
- Read capture: when rom_dvalid_i=1, rom_dout_i is pushed into the FIFO. The credit rule guarantees no overflow.
  - rom_dvalid_i while no read is in flight (including in IDLE) is ignored.
- RAM write rule: ram_req_o=1 iff the FIFO is non-empty (COPY only).
  - ram_wdata_o is the FIFO head; ram_addr_o = dst + writes_done, mod 2^RamAw.
  - Address and data stay stable while ram_req_o=1 and ram_gnt_i=0.
  - On ram_gnt_i=1: pop, writes_done++, checksum += word (mod 2^Width, visible next cycle).
  - ram_gnt_i while ram_req_o=0 is ignored.
- Push and pop in the same cycle: fifo_count is unchanged, and order is preserved.
- Latency: with ram_gnt_i tied 1, start is in cycle 0.
  - First rom_cs_o in cycle 1; first ram_req_o in cycle 3.
  - One word per cycle after that.
  - done_o rises in cycle len+3.
- Backpressure: with ram_gnt_i low, reads continue until the FIFO plus in-flight read reach FifoDepth, then stall. No data is lost or duplicated.

Test Plan:
- Basic copy: ROM[0x010..0x013] = 0x11111111, 0x22222222, 0x33333333, 0x44444444; src=0x010, dst=0x0200, len=4, gnt=1 -> RAM 0x0200..0x0203 receive those words in order; checksum_o=0xAAAAAAAA; done_o high in cycle 7.
- Zero length: len=0, start -> no rom_cs_o or ram_req_o; busy_o for 1 cycle; done_o=1; checksum_o=0.
- Backpressure: len=8, ram_gnt_i low for 10 cycles, then toggling every 3rd cycle -> at most 4 reads outstanding; ram_addr_o and ram_wdata_o stable while ungranted; all 8 words correct and in order.
- Address wrap: src=0xFFE, dst=0x3FFF, len=3 -> ROM addresses 0xFFE, 0xFFF, 0x000; RAM addresses 0x3FFF, 0x0000, 0x0001.
- Checksum overflow: words 0xFFFFFFFF and 0x00000002 -> checksum_o=0x00000001.
- Reset mid-op: assert rst_ni=0 after 3 granted writes of len=16 -> all outputs 0 in that cycle; after release, no RAM writes; a fresh start with len=2 copies correctly and reports the checksum of 2 words only.

Source files
------------

// File: rtl/boot_rom_copy_engine.sv
// rtl/boot_rom_copy_engine.sv - boot ROM to SRAM shadow copy engine with running checksum
//
// Purpose: copies len_i words from the boot ROM (starting at src_addr_i) into main
// SRAM (starting at dst_addr_i). Each word written is added to checksum_o.
// ROM reads are credit limited so the read-data FIFO never overflows.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   start_i                  one-cycle pulse, accepted in IDLE/DONE only
//   src_addr_i, dst_addr_i   first ROM / RAM word address
//   len_i                    word count, 0..2^RomAw
//   busy_o, done_o           copy in progress / sticky completion
//   checksum_o               sum of all words written, mod 2^Width
//   rom_cs_o, rom_addr_o     ROM read strobe and word address
//   rom_dout_i, rom_dvalid_i ROM read data, valid one cycle after rom_cs_o
//   ram_req_o, ram_we_o      RAM write request (write enable mirrors it)
//   ram_addr_o, ram_wdata_o  RAM word address and write data
//   ram_gnt_i                RAM accepts the current request
module boot_rom_copy_engine #(
   parameter int Width     = 32,
   parameter int RomAw     = 12,
   parameter int RamAw     = 14,
   parameter int FifoDepth = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic [RomAw-1:0] src_addr_i,
   input  logic [RamAw-1:0] dst_addr_i,
   input  logic [RomAw:0]   len_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [Width-1:0] checksum_o,
   output logic             rom_cs_o,
   output logic [RomAw-1:0] rom_addr_o,
   input  logic [Width-1:0] rom_dout_i,
   input  logic             rom_dvalid_i,
   output logic             ram_req_o,
   output logic             ram_we_o,
   output logic [RamAw-1:0] ram_addr_o,
   output logic [Width-1:0] ram_wdata_o,
   input  logic             ram_gnt_i
);

   localparam int PtrW = $clog2(FifoDepth);
   localparam int CntW = PtrW + 1;
   localparam int LenW = RomAw + 1;
   localparam logic [CntW:0] LevelMax = (CntW + 1)'(FifoDepth);

   typedef enum logic [1:0] {
      IDLE,
      COPY,
      DONE
   } state_e;

   state_e           state_q, state_d;
   logic [RomAw-1:0] src_q, src_d;
   logic [RamAw-1:0] dst_q, dst_d;
   logic [LenW-1:0]  len_q, len_d;
   logic [LenW-1:0]  rd_cnt_q, rd_cnt_d;
   logic [LenW-1:0]  wr_cnt_q, wr_cnt_d;
   logic             inflight_q, inflight_d;
   logic [RomAw-1:0] rom_addr_q, rom_addr_d;
   logic [Width-1:0] checksum_q, checksum_d;
   logic [Width-1:0] fifo_mem_q [FifoDepth];
   logic [Width-1:0] fifo_mem_d [FifoDepth];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  fifo_cnt_q, fifo_cnt_d;

   logic [CntW:0]    fifo_level;
   logic             rom_cs;
   logic             push;
   logic             pop;
   logic             ram_req;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         src_q      <= '0;
         dst_q      <= '0;
         len_q      <= '0;
         rd_cnt_q   <= '0;
         wr_cnt_q   <= '0;
         inflight_q <= 1'b0;
         rom_addr_q <= '0;
         checksum_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fifo_cnt_q <= '0;
         for (int i = 0; i < FifoDepth; i++) begin
            fifo_mem_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         src_q      <= src_d;
         dst_q      <= dst_d;
         len_q      <= len_d;
         rd_cnt_q   <= rd_cnt_d;
         wr_cnt_q   <= wr_cnt_d;
         inflight_q <= inflight_d;
         rom_addr_q <= rom_addr_d;
         checksum_q <= checksum_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         fifo_cnt_q <= fifo_cnt_d;
         fifo_mem_q <= fifo_mem_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      src_d      = src_q;
      dst_d      = dst_q;
      len_d      = len_q;
      rd_cnt_d   = rd_cnt_q;
      wr_cnt_d   = wr_cnt_q;
      rom_addr_d = rom_addr_q;
      checksum_d = checksum_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      fifo_cnt_d = fifo_cnt_q;
      fifo_mem_d = fifo_mem_q;

      // Credit: buffered words plus the read whose data returns this cycle must
      // leave room for one more word, otherwise the next push could overflow.
      fifo_level = {1'b0, fifo_cnt_q} + {{CntW{1'b0}}, inflight_q};
      rom_cs     = (state_q == COPY) && (rd_cnt_q < len_q) && (fifo_level < LevelMax);
      // Data valid only counts when it answers a strobe from the previous cycle;
      // this also drops a response whose strobe was cut off by reset.
      push       = (state_q == COPY) && inflight_q && rom_dvalid_i;
      ram_req    = (state_q == COPY) && (fifo_cnt_q != '0);
      pop        = ram_req && ram_gnt_i;
      inflight_d = rom_cs;

      if (rom_cs) begin
         rom_addr_d = src_q + rd_cnt_q[RomAw-1:0];
         rd_cnt_d   = rd_cnt_q + LenW'(1);
      end

      if (push) begin
         fifo_mem_d[wr_ptr_q] = rom_dout_i;
         wr_ptr_d             = wr_ptr_q + PtrW'(1);
      end

      if (pop) begin
         rd_ptr_d   = rd_ptr_q + PtrW'(1);
         wr_cnt_d   = wr_cnt_q + LenW'(1);
         checksum_d = checksum_q + fifo_mem_q[rd_ptr_q];
      end

      case ({push, pop})
         2'b10:   fifo_cnt_d = fifo_cnt_q + CntW'(1);
         2'b01:   fifo_cnt_d = fifo_cnt_q - CntW'(1);
         default: fifo_cnt_d = fifo_cnt_q;
      endcase

      case (state_q)
         IDLE, DONE: begin
            if (start_i) begin
               state_d    = COPY;
               src_d      = src_addr_i;
               dst_d      = dst_addr_i;
               len_d      = len_i;
               rd_cnt_d   = '0;
               wr_cnt_d   = '0;
               checksum_d = '0;
               wr_ptr_d   = '0;
               rd_ptr_d   = '0;
               fifo_cnt_d = '0;
            end
         end
         COPY: begin
            if ((len_q == '0) || (pop && (wr_cnt_d == len_q))) begin
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy_o      = (state_q == COPY);
   assign done_o      = (state_q == DONE);
   assign checksum_o  = checksum_q;
   assign rom_cs_o    = rom_cs;
   // Address is presented combinationally with the strobe and held otherwise.
   assign rom_addr_o  = rom_addr_d;
   assign ram_req_o   = ram_req;
   assign ram_we_o    = ram_req;
   assign ram_addr_o  = ram_req ? (dst_q + RamAw'(wr_cnt_q)) : '0;
   assign ram_wdata_o = ram_req ? fifo_mem_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_boot_rom_copy_engine.sv
// tb/tb_boot_rom_copy_engine.sv - self-checking bench for boot_rom_copy_engine
module tb_boot_rom_copy_engine;

   localparam int FD = 4;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        start_i;
   logic [11:0] src_addr_i;
   logic [13:0] dst_addr_i;
   logic [12:0] len_i;
   logic        busy_o;
   logic        done_o;
   logic [31:0] checksum_o;
   logic        rom_cs_o;
   logic [11:0] rom_addr_o;
   logic [31:0] rom_dout_i;
   logic        rom_dvalid_i;
   logic        ram_req_o;
   logic        ram_we_o;
   logic [13:0] ram_addr_o;
   logic [31:0] ram_wdata_o;
   logic        ram_gnt_i;

   boot_rom_copy_engine dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .start_i      (start_i),
      .src_addr_i   (src_addr_i),
      .dst_addr_i   (dst_addr_i),
      .len_i        (len_i),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .checksum_o   (checksum_o),
      .rom_cs_o     (rom_cs_o),
      .rom_addr_o   (rom_addr_o),
      .rom_dout_i   (rom_dout_i),
      .rom_dvalid_i (rom_dvalid_i),
      .ram_req_o    (ram_req_o),
      .ram_we_o     (ram_we_o),
      .ram_addr_o   (ram_addr_o),
      .ram_wdata_o  (ram_wdata_o),
      .ram_gnt_i    (ram_gnt_i)
   );

   always #5 clk_i = ~clk_i;

   logic [31:0] rom_mem [4096];

   int          n_tests;
   int          n_fail;

   bit          job_active;
   int          job_cycle;
   int          m_src, m_dst, m_len;
   int          m_reads, m_reads_lag, m_grants;
   int          m_max_out, m_busy_cnt;
   int          m_first_cs, m_first_req, m_done_cyc;
   logic [31:0] m_sum;
   int          gnt_mode;
   bit          stray;

   bit          cs_seen;
   logic [11:0] addr_seen;
   logic [11:0] last_rom_addr;
   bit          prev_req, prev_gnt;
   logic [13:0] prev_addr;
   logic [31:0] prev_data;
   logic [11:0] rd_log [32];
   logic [13:0] wr_addr_log [32];
   logic [31:0] wr_data_log [32];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Reference behaviour from word counts: a read may issue while fewer than
   // FD words are outstanding; a word is writable two cycles after its read;
   // the job is done the cycle after the last granted write.
   task automatic monitor();
      int          r0, g0;
      bit          exp_done, in_copy, exp_cs, exp_req;
      logic [31:0] exp_word;
      cs_seen   = rom_cs_o;
      addr_seen = rom_addr_o;
      if (!rst_ni) begin
         prev_req      = 1'b0;
         prev_gnt      = 1'b0;
         last_rom_addr = '0;
      end else begin
         r0       = m_reads;
         g0       = m_grants;
         exp_done = job_active && (job_cycle >= 2) && (g0 == m_len);
         in_copy  = job_active && (job_cycle >= 1) && !exp_done;
         exp_cs   = in_copy && (r0 < m_len) && ((r0 - g0) < FD);
         exp_req  = job_active && (m_reads_lag > g0);
         check("rom_cs", 32'(rom_cs_o), 32'(exp_cs));
         check("ram_req", 32'(ram_req_o), 32'(exp_req));
         check("ram_we", 32'(ram_we_o), 32'(exp_req));
         if (job_active && job_cycle >= 1) begin
            check("busy", 32'(busy_o), 32'(!exp_done));
            check("done", 32'(done_o), 32'(exp_done));
            check("checksum", checksum_o, m_sum);
         end else if (!job_active) begin
            check("idle_busy", 32'(busy_o), 32'd0);
            check("idle_done", 32'(done_o), 32'd0);
            check("idle_checksum", checksum_o, 32'd0);
         end
         if (rom_cs_o) begin
            check("rom_addr", 32'(rom_addr_o), (m_src + r0) % 4096);
            if (r0 < 32) rd_log[r0] = rom_addr_o;
            last_rom_addr = rom_addr_o;
            m_reads++;
            if (m_first_cs < 0) m_first_cs = job_cycle;
         end else begin
            check("rom_addr_hold", 32'(rom_addr_o), 32'(last_rom_addr));
         end
         if (ram_req_o) begin
            exp_word = rom_mem[(m_src + g0) % 4096];
            check("ram_addr", 32'(ram_addr_o), (m_dst + g0) % 16384);
            check("ram_wdata", ram_wdata_o, exp_word);
            if (prev_req && !prev_gnt) begin
               check("ram_addr_stable", 32'(ram_addr_o), 32'(prev_addr));
               check("ram_wdata_stable", ram_wdata_o, prev_data);
            end
            if (m_first_req < 0) m_first_req = job_cycle;
            if (ram_gnt_i) begin
               if (g0 < 32) begin
                  wr_addr_log[g0] = ram_addr_o;
                  wr_data_log[g0] = ram_wdata_o;
               end
               m_sum = m_sum + exp_word;
               m_grants++;
            end
         end
         prev_req  = ram_req_o;
         prev_gnt  = ram_gnt_i;
         prev_addr = ram_addr_o;
         prev_data = ram_wdata_o;
         if ((m_reads - m_grants) > m_max_out) m_max_out = m_reads - m_grants;
         if (job_active && busy_o) m_busy_cnt++;
         if (job_active && done_o && job_cycle >= 1 && m_done_cyc < 0) m_done_cyc = job_cycle;
         m_reads_lag = r0;
         job_cycle++;
      end
   endtask

   // One clock: sample/compare on the falling edge, then act as ROM and RAM
   // just after the rising edge.
   task automatic tick();
      @(negedge clk_i);
      monitor();
      @(posedge clk_i);
      #1;
      rom_dvalid_i = cs_seen | stray;
      rom_dout_i   = cs_seen ? rom_mem[addr_seen] : $urandom();
      if (gnt_mode == 0) ram_gnt_i = 1'b1;
      else ram_gnt_i = (job_cycle > 10) && (job_cycle % 3 == 0);
   endtask

   task automatic start_job(input int src, input int dst, input int len, input int mode);
      m_src       = src;
      m_dst       = dst;
      m_len       = len;
      m_reads     = 0;
      m_reads_lag = 0;
      m_grants    = 0;
      m_max_out   = 0;
      m_busy_cnt  = 0;
      m_first_cs  = -1;
      m_first_req = -1;
      m_done_cyc  = -1;
      m_sum       = '0;
      gnt_mode    = mode;
      job_cycle   = 0;
      job_active  = 1'b1;
      src_addr_i  = 12'(src);
      dst_addr_i  = 14'(dst);
      len_i       = 13'(len);
      start_i     = 1'b1;
      tick();
      start_i     = 1'b0;
   endtask

   task automatic run_job(input int src, input int dst, input int len, input int mode);
      start_job(src, dst, len, mode);
      for (int i = 0; i < 400 && m_done_cyc < 0; i++) tick();
      check("job_completes", 32'(m_done_cyc >= 0), 32'd1);
   endtask

   initial begin
      n_tests      = 0;
      n_fail       = 0;
      job_active   = 1'b0;
      job_cycle    = 0;
      m_src = 0; m_dst = 0; m_len = 0;
      m_reads = 0; m_reads_lag = 0; m_grants = 0;
      m_max_out = 0; m_busy_cnt = 0;
      m_first_cs = -1; m_first_req = -1; m_done_cyc = -1;
      m_sum        = '0;
      gnt_mode     = 0;
      stray        = 1'b0;
      prev_req     = 1'b0;
      prev_gnt     = 1'b0;
      prev_addr    = '0;
      prev_data    = '0;
      last_rom_addr = '0;
      rst_ni       = 1'b0;
      start_i      = 1'b0;
      src_addr_i   = '0;
      dst_addr_i   = '0;
      len_i        = '0;
      rom_dout_i   = '0;
      rom_dvalid_i = 1'b0;
      ram_gnt_i    = 1'b0;

      for (int i = 0; i < 4096; i++) rom_mem[i] = 32'(i) * 32'h9E3779B1 + 32'h12345678;
      rom_mem[12'h010] = 32'h11111111;
      rom_mem[12'h011] = 32'h22222222;
      rom_mem[12'h012] = 32'h33333333;
      rom_mem[12'h013] = 32'h44444444;
      rom_mem[12'h020] = 32'hFFFFFFFF;
      rom_mem[12'h021] = 32'h00000002;
      rom_mem[12'h100] = 32'h00001000;
      rom_mem[12'h101] = 32'h00000234;

      repeat (3) tick();
      rst_ni = 1'b1;
      tick();
      check("reset_busy", 32'(busy_o), 32'd0);
      check("reset_done", 32'(done_o), 32'd0);
      check("reset_checksum", checksum_o, 32'd0);
      check("reset_rom_cs", 32'(rom_cs_o), 32'd0);
      check("reset_ram_req", 32'(ram_req_o), 32'd0);

      // Stray ROM data valid while idle must not create a write.
      stray = 1'b1;
      repeat (3) tick();
      stray = 1'b0;
      repeat (2) tick();

      // Basic copy.
      run_job(12'h010, 14'h0200, 4, 0);
      check("basic_first_cs_cycle", 32'(m_first_cs), 32'd1);
      check("basic_first_req_cycle", 32'(m_first_req), 32'd3);
      check("basic_done_cycle", 32'(m_done_cyc), 32'd7);
      check("basic_checksum", checksum_o, 32'hAAAAAAAA);
      for (int i = 0; i < 4; i++) begin
         check("basic_wr_addr", 32'(wr_addr_log[i]), 32'h200 + 32'(i));
         check("basic_wr_data", wr_data_log[i], 32'h11111111 * 32'(i + 1));
      end

      // Zero length, started from DONE.
      run_job(12'h010, 14'h0200, 0, 0);
      check("zero_reads", 32'(m_reads), 32'd0);
      check("zero_writes", 32'(m_grants), 32'd0);
      check("zero_busy_cycles", 32'(m_busy_cnt), 32'd1);
      check("zero_done_cycle", 32'(m_done_cyc), 32'd2);
      check("zero_checksum", checksum_o, 32'd0);

      // Backpressure: grant low 10 cycles, then one cycle in three.
      run_job(12'h040, 14'h1000, 8, 1);
      check("bp_max_outstanding", 32'(m_max_out), 32'd4);
      check("bp_writes", 32'(m_grants), 32'd8);

      // Address wrap on both sides.
      run_job(12'hFFE, 14'h3FFF, 3, 0);
      check("wrap_rd0", 32'(rd_log[0]), 32'h0FFE);
      check("wrap_rd1", 32'(rd_log[1]), 32'h0FFF);
      check("wrap_rd2", 32'(rd_log[2]), 32'h0000);
      check("wrap_wr0", 32'(wr_addr_log[0]), 32'h3FFF);
      check("wrap_wr1", 32'(wr_addr_log[1]), 32'h0000);
      check("wrap_wr2", 32'(wr_addr_log[2]), 32'h0001);

      // Checksum overflow.
      run_job(12'h020, 14'h0010, 2, 0);
      check("ovf_checksum", checksum_o, 32'h00000001);

      // Reset in the middle of a long copy.
      start_job(12'h100, 14'h0800, 16, 0);
      for (int i = 0; i < 100 && m_grants < 3; i++) tick();
      check("rst_reached_3_writes", 32'(m_grants), 32'd3);
      rst_ni = 1'b0;
      #1;
      check("rst_rom_cs", 32'(rom_cs_o), 32'd0);
      check("rst_rom_addr", 32'(rom_addr_o), 32'd0);
      check("rst_ram_req", 32'(ram_req_o), 32'd0);
      check("rst_ram_we", 32'(ram_we_o), 32'd0);
      check("rst_ram_addr", 32'(ram_addr_o), 32'd0);
      check("rst_ram_wdata", ram_wdata_o, 32'd0);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_done", 32'(done_o), 32'd0);
      check("rst_checksum", checksum_o, 32'd0);
      job_active = 1'b0;
      tick();
      stray = 1'b1;
      tick();
      rst_ni = 1'b1;
      stray  = 1'b0;
      repeat (6) tick();
      run_job(12'h100, 14'h0800, 2, 0);
      check("post_rst_writes", 32'(m_grants), 32'd2);
      check("post_rst_checksum", checksum_o, 32'h00001234);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
